montgomery_multiply_core: RTL and testbench

MONTGOMERY_MULTIPLY_CORE -- requirements
Module: montgomery_multiply

---
 rtl/montgomery_multiply_core.sv | 141 ++++++++++++++
 tb/tb_montgomery_multiply_core.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/montgomery_multiply_core.sv
// ---------------------------------------------------------------------------
// montgomery_multiply_core
//
// A fully pipelined 12-bit Montgomery multiplier. It computes
//   result = a * b * R^-1 mod Q,  with R = 4096,
// and reduces the result fully into [0, Q-1]. It accepts one operation per
// clock. It has no stalls and no backpressure.
//
// Pipeline:
//   stage 0 : a, b and en registered at the sampling edge
//   stage 1 : P = a*b                              (24 bits)
//   stage 2 : m = (P[11:0]*QPRIME) mod 4096        (12 bits), P forwarded
//   stage 3 : t = (P + m*Q) >> 12                  (13 bits, t < 2Q)
//   final   : result = (t >= Q) ? t-Q : t
//
// Optional feature (macro MONT_OUT_REG_EN):
//   defined   -> the final subtraction and valid are registered, latency 4
//   undefined -> result/valid are combinational from stage 3,   latency 3
// An input sampled at edge k appears with valid=1 after edge k+latency.
//
// Parameters:
//   Q      : odd modulus below 4096 (default 3329)
//   QPRIME : -Q^-1 mod 4096          (default 3327)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset; flushes every in-flight operation
//   en     in   input-valid strobe; a/b are sampled on each edge with en=1
//   a      in   [11:0] multiplicand, expected in [0, Q-1]
//   b      in   [11:0] multiplier,   expected in [0, Q-1]
//   result out  [11:0] Montgomery product; holds its value across bubbles
//   valid  out  high for exactly one cycle per accepted input
// ---------------------------------------------------------------------------
module montgomery_multiply_core #(
    parameter int unsigned Q      = 3329,
    parameter int unsigned QPRIME = 3327
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic [11:0] result,
    output logic        valid
);

    // Stage 0: input capture
    logic [11:0] a_q;
    logic [11:0] b_q;
    logic        v0;

    // Stage 1: full product
    logic [23:0] p1;
    logic        v1;

    // Stage 2: Montgomery quotient, product forwarded
    logic [11:0] m2;
    logic [23:0] p2;
    logic        v2;

    // Stage 3: reduced value, still in [0, 2Q)
    logic [12:0] t3;
    logic        v3;

    // Next-stage combinational values
    logic [23:0] p_next;
    logic [11:0] m_next;
    logic [12:0] t_next;
    logic [11:0] res_next;

    always_comb begin
        p_next   = a_q * b_q;
        // Only the low 12 bits of the product are kept. That is the mod 4096.
        m_next   = p1[11:0] * 12'(QPRIME);
        // The low 12 bits of P + m*Q are zero by construction of m, so the
        // shift is an exact division by R.
        t_next   = 13'(({1'b0, p2} + 25'(m2) * 25'(Q)) >> 12);
        res_next = 12'((t3 >= 13'(Q)) ? (t3 - 13'(Q)) : t3);
    end

    // The valid bits shift through the pipeline on every edge. A data
    // register loads only when its incoming valid bit is set. A bubble
    // therefore leaves the data untouched, and result holds its old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            v0  <= 1'b0;
            p1  <= '0;
            v1  <= 1'b0;
            m2  <= '0;
            p2  <= '0;
            v2  <= 1'b0;
            t3  <= '0;
            v3  <= 1'b0;
        end else begin
            v0 <= en;
            v1 <= v0;
            v2 <= v1;
            v3 <= v2;
            if (en) begin
                a_q <= a;
                b_q <= b;
            end
            if (v0) begin
                p1 <= p_next;
            end
            if (v1) begin
                m2 <= m_next;
                p2 <= p1;
            end
            if (v2) begin
                t3 <= t_next;
            end
        end
    end

`ifdef MONT_OUT_REG_EN
    logic [11:0] result_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= v3;
            if (v3) begin
                result_q <= res_next;
            end
        end
    end

    assign result = result_q;
    assign valid  = valid_q;
`else
    assign result = res_next;
    assign valid  = v3;
`endif

endmodule

// File: tb/tb_montgomery_multiply_core.sv
// ---------------------------------------------------------------------------
// tb_montgomery_multiply_core
//
// A directed self-checking bench for montgomery_multiply_core. The bench
// applies every input through drive(), which also records the result
// expected L edges later. After each edge, tick() checks valid and result
// against that record.
// ---------------------------------------------------------------------------
module tb_montgomery_multiply_core;

`ifdef MONT_OUT_REG_EN
    localparam int L = 4;
`else
    localparam int L = 3;
`endif
    localparam int QM   = 3329;
    localparam int HIST = 4096;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [11:0] a     = '0;
    logic [11:0] b     = '0;
    logic [11:0] result;
    logic        valid;

    montgomery_multiply_core #(
        .Q      (3329),
        .QPRIME (3327)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .a      (a),
        .b      (b),
        .result (result),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    int    checks    = 0;
    int    errors    = 0;
    int    n         = 0;     // rising edges seen so far
    int    model_res = 0;     // value result is expected to hold
    int    rinv      = 0;     // 4096^-1 mod 3329
    int    valid_cnt = 0;
    string phase     = "init";
    bit    in_v [0:HIST-1];
    int    in_r [0:HIST-1];

    function automatic int golden(input int x, input int y);
        return (((x * y) % QM) * rinv) % QM;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s/%s: observed %0d expected %0d (edge %0d)", phase, tag, obs, expv, n);
        end
    endtask

    task automatic tick();
        int idx;
        bit ev;
        @(posedge clk);
        #1;
        n++;
        idx = n - L;
        ev  = (idx >= 0) ? in_v[idx] : 1'b0;
        if (!rst_n) begin
            ev        = 1'b0;
            model_res = 0;
        end else if (ev) begin
            model_res = in_r[idx];
        end
        if (ev) valid_cnt++;
        check("valid", 32'(valid), 32'(ev));
        check("result", 32'(result), 32'(model_res));
    endtask

    // The inputs set now are sampled at edge n+1.
    task automatic drive(input bit e, input int x, input int y, input int expres);
        en  = e;
        a   = 12'(x);
        b   = 12'(y);
        in_v[n+1] = e && rst_n;
        in_r[n+1] = expres;
        tick();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b0, $urandom_range(0, 4095), $urandom_range(0, 4095), 0);
        end
    endtask

    task automatic reset_pulse();
        en    = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < HIST; i++) in_v[i] = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int x;
        int y;
        for (int i = 1; i < QM; i++) begin
            if (((4096 * i) % QM) == 1) rinv = i;
        end
        for (int i = 0; i < HIST; i++) begin
            in_v[i] = 1'b0;
            in_r[i] = 0;
        end

        // Check the reset state.
        phase = "reset";
        tick();
        tick();
        rst_n = 1'b1;
        idle(2);

        // Hand-computed vectors. 767 is R mod Q, so a*767 maps back to a.
        phase = "directed";
        drive(1'b1, 1, 767, 1);
        idle(L + 1);
        drive(1'b1, 767, 767, 767);
        drive(1'b1, 3328, 767, 3328);
        drive(1'b1, 0, 1234, 0);
        drive(1'b1, 767, 1, 1);
        idle(L + 1);

        // Bubble pattern 1,0,1,1,0. Result must hold during the gaps.
        phase = "bubble";
        drive(1'b1, 5, 767, 5);
        drive(1'b0, 77, 99, 0);
        drive(1'b1, 3000, 767, 3000);
        drive(1'b1, 1234, 767, 1234);
        drive(1'b0, 11, 22, 0);
        idle(L + 1);

        // Back-to-back random stream checked against the golden model.
        phase     = "random";
        valid_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            x = $urandom_range(0, QM - 1);
            y = $urandom_range(0, QM - 1);
            drive(1'b1, x, y, golden(x, y));
        end
        idle(L + 1);
        check("pulse_count", 32'(valid_cnt), 32'd512);

        // Reset with three operations in flight. Nothing may emerge afterwards.
        phase = "midreset";
        drive(1'b1, 100, 200, golden(100, 200));
        drive(1'b1, 300, 400, golden(300, 400));
        drive(1'b1, 500, 600, golden(500, 600));
        reset_pulse();
        idle(L + 3);

        // The first operation after reset must arrive exactly L edges later.
        phase = "post_reset";
        drive(1'b1, 2, 767, 2);
        idle(L + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
